led_gradient_fader: RTL and testbench

Parametrised, multi-channel successor to the single-channel LED colour mixer. It maps each channel's index (`contador`) onto a green→yellow→red gradient set by `mid_idx`/`max_idx`. It uses one time-shared sequential divider and an optional per-frame fade toward the target colour. It sits between the game-state counters and the LED driver, and it owns the registered colour outputs for all LEDs.

---
 rtl/led_gradient_fader_if.sv | 24 ++
 rtl/led_gradient_fader.sv | 191 +++++++++++++++++++
 tb/tb_led_gradient_fader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/led_gradient_fader_if.sv
// Bundles the frame control, snapshot inputs and colour/status outputs of led_gradient_fader.
interface led_gradient_fader_if #(
  parameter int N  = 8,
  parameter int CH = 4
);
  logic              enable;
  logic              fade_en;
  logic [CH*N-1:0]   contador;
  logic [N-1:0]      mid_idx;
  logic [N-1:0]      max_idx;
  logic [CH*24-1:0]  cor_led;
  logic              busy;
  logic              frame_done;

  modport master (
    output enable, fade_en, contador, mid_idx, max_idx,
    input  cor_led, busy, frame_done
  );

  modport slave (
    input  enable, fade_en, contador, mid_idx, max_idx,
    output cor_led, busy, frame_done
  );
endinterface

// File: rtl/led_gradient_fader.sv
// Multi-channel green->yellow->red gradient mapper with a shared serial divider and per-frame fade.
// The interface instance must use the same N and CH as this module.
module led_gradient_fader #(
  parameter int N    = 8,
  parameter int CH   = 4,
  parameter int STEP = 16
) (
  input logic              clock,
  input logic              reset,
  led_gradient_fader_if.slave bus
);

  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int DW  = N + 8;
  localparam int CW  = $clog2(DW + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DIV    = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] SEG_A = 2'd0;
  localparam logic [1:0] SEG_B = 2'd1;
  localparam logic [1:0] SEG_C = 2'd2;

  logic [2:0]       state_q, state_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [CH*N-1:0]  cont_q, cont_d;
  logic [N-1:0]     mid_q, mid_d;
  logic [N-1:0]     emax_q, emax_d;
  logic             fade_q, fade_d;
  logic [DW-1:0]    num_q, num_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     den_q, den_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       seg_q, seg_d;
  logic             div_q, div_d;
  logic [CH*24-1:0] cor_q, cor_d;

  logic [N-1:0]     idx;
  logic [N-1:0]     diff;
  logic [N:0]       rem_sh;
  logic [N-1:0]     rem_sub;
  logic [7:0]       quot8;
  logic [23:0]      target;
  logic [23:0]      cur;
  logic [23:0]      faded;

  // One component moves toward its target by at most STEP; 9-bit so neither direction wraps.
  function automatic logic [7:0] step_to(input logic [7:0] c, input logic [7:0] t);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, c} + 9'(STEP);
    dn = {1'b0, c} - 9'(STEP);
    if (c < t)
      step_to = (up > {1'b0, t}) ? t : up[7:0];
    else if (c > t)
      step_to = (dn[8] || (dn < {1'b0, t})) ? t : dn[7:0];
    else
      step_to = c;
  endfunction

  // Frame sequencing, channel target selection, serial division and colour update.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cont_d  = cont_q;
    mid_d   = mid_q;
    emax_d  = emax_q;
    fade_d  = fade_q;
    num_d   = num_q;
    rem_d   = rem_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    div_d   = div_q;
    cor_d   = cor_q;

    idx     = cont_q[int'(ch_q)*N +: N];
    diff    = idx - mid_q;
    rem_sh  = {rem_q, num_q[DW-1]};
    rem_sub = rem_sh[N-1:0] - den_q;
    quot8   = div_q ? ((|num_q[DW-1:8]) ? 8'hFF : num_q[7:0]) : 8'hFF;
    case (seg_q)
      SEG_A:   target = {quot8, 8'hFF, 8'h00};
      SEG_B:   target = {8'hFF, 8'hFF - quot8, 8'h00};
      default: target = 24'hFF0000;
    endcase
    cur   = cor_q[int'(ch_q)*24 +: 24];
    faded = {step_to(cur[23:16], target[23:16]),
             step_to(cur[15:8],  target[15:8]),
             step_to(cur[7:0],   target[7:0])};

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          cont_d  = bus.contador;
          mid_d   = bus.mid_idx;
          emax_d  = (bus.max_idx > bus.mid_idx) ? bus.max_idx : bus.mid_idx;
          fade_d  = bus.fade_en;
          ch_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rem_d = '0;
        cnt_d = '0;
        if (idx <= mid_q) begin
          seg_d = SEG_A;
          num_d = {idx, 8'h00} - {8'h00, idx};
          den_d = mid_q;
        end else if (idx <= emax_q) begin
          seg_d = SEG_B;
          num_d = {diff, 8'h00} - {8'h00, diff};
          den_d = emax_q - mid_q;
        end else begin
          seg_d = SEG_C;
        end
        div_d   = (seg_d != SEG_C) && (den_d != '0);
        state_d = div_d ? S_DIV : S_UPDATE;
      end
      S_DIV: begin
        // num_q shifts out the dividend MSB-first and shifts in quotient bits.
        if (rem_sh >= {1'b0, den_q}) begin
          rem_d = rem_sub;
          num_d = {num_q[DW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[N-1:0];
          num_d = {num_q[DW-2:0], 1'b0};
        end
        if (cnt_q == CW'(DW - 1))
          state_d = S_UPDATE;
        else
          cnt_d = cnt_q + 1'b1;
      end
      S_UPDATE: begin
        cor_d[int'(ch_q)*24 +: 24] = fade_q ? faded : target;
        if (ch_q == CHW'(CH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        ch_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      cont_q  <= '0;
      mid_q   <= '0;
      emax_q  <= '0;
      fade_q  <= 1'b0;
      num_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= SEG_A;
      div_q   <= 1'b0;
      cor_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cont_q  <= cont_d;
      mid_q   <= mid_d;
      emax_q  <= emax_d;
      fade_q  <= fade_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      div_q   <= div_d;
      cor_q   <= cor_d;
    end
  end

  assign bus.cor_led    = cor_q;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_DIV) || (state_q == S_UPDATE);
  assign bus.frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_led_gradient_fader.sv
// Self-checking bench for led_gradient_fader against an arithmetic gradient/fade model.
module tb_led_gradient_fader;
  localparam int N    = 8;
  localparam int CH   = 4;
  localparam int STEP = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  led_gradient_fader_if #(.N(N), .CH(CH)) bus ();

  led_gradient_fader #(.N(N), .CH(CH), .STEP(STEP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [23:0] exp_cor [CH];
  int exp_len;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Gradient colour straight from the segment rules; divides tells whether the divider runs.
  function automatic logic [23:0] ref_colour(input int idx, input int mid, input int mx,
                                             output bit divides);
    int emax;
    int q;
    emax = (mx > mid) ? mx : mid;
    divides = 1'b0;
    if (idx <= mid) begin
      if (mid == 0) q = 255;
      else begin q = (idx * 255) / mid; divides = 1'b1; end
      if (q > 255) q = 255;
      return {q[7:0], 8'hFF, 8'h00};
    end else if (idx <= emax) begin
      q = ((idx - mid) * 255) / (emax - mid);
      divides = 1'b1;
      if (q > 255) q = 255;
      q = 255 - q;
      return {8'hFF, q[7:0], 8'h00};
    end
    return 24'hFF0000;
  endfunction

  function automatic int fade_ref(input int c, input int t);
    if (c < t) return (c + STEP < t) ? c + STEP : t;
    if (c > t) return (c - STEP > t) ? c - STEP : t;
    return c;
  endfunction

  task automatic model_frame(input logic [31:0] cont, input int mid, input int mx, input bit fade);
    logic [23:0] tgt;
    logic [23:0] c;
    bit dv;
    int r, g, b;
    exp_len = 1;
    for (int k = 0; k < CH; k++) begin
      tgt = ref_colour(int'(cont[k*N +: N]), mid, mx, dv);
      exp_len += dv ? (N + 10) : 2;
      c = exp_cor[k];
      if (fade) begin
        r = fade_ref(int'(c[23:16]), int'(tgt[23:16]));
        g = fade_ref(int'(c[15:8]),  int'(tgt[15:8]));
        b = fade_ref(int'(c[7:0]),   int'(tgt[7:0]));
        exp_cor[k] = {r[7:0], g[7:0], b[7:0]};
      end else begin
        exp_cor[k] = tgt;
      end
    end
  endtask

  task automatic start_frame(input logic [31:0] cont, input logic [7:0] mid, input logic [7:0] mx,
                             input bit fade);
    @(negedge clock);
    bus.contador = cont;
    bus.mid_idx  = mid;
    bus.max_idx  = mx;
    bus.fade_en  = fade;
    bus.enable   = 1'b1;
    model_frame(cont, int'(mid), int'(mx), fade);
  endtask

  // Follows one frame to its frame_done, then checks length, pulse, idle return and colours.
  task automatic wait_frame(input bit hold_en, input bit perturb, input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int t = 0;
    logic first_busy;
    @(negedge clock);
    first_busy = bus.busy;
    if (!hold_en) bus.enable = 1'b0;
    if (bus.busy) busy_cnt++;
    while (done_cnt == 0 && t < 2000) begin
      @(negedge clock);
      t++;
      if (bus.busy) busy_cnt++;
      if (bus.frame_done) done_cnt++;
      if (perturb && bus.busy) begin
        bus.contador = $urandom;
        bus.mid_idx  = 8'($urandom);
        bus.max_idx  = 8'($urandom);
        bus.fade_en  = 1'($urandom);
      end
    end
    @(negedge clock);
    if (bus.frame_done) done_cnt++;
    chk({tag, "_start"}, 96'(first_busy), 96'd1);
    chk({tag, "_done_pulses"}, 96'(done_cnt), 96'd1);
    chk({tag, "_idle_after"}, 96'(bus.busy), 96'd0);
    chk({tag, "_length"}, 96'(busy_cnt + 1), 96'(exp_len));
    for (int k = 0; k < CH; k++)
      chk($sformatf("%s_cor%0d", tag, k), 96'(bus.cor_led[k*24 +: 24]), 96'(exp_cor[k]));
  endtask

  task automatic do_frame(input logic [31:0] cont, input logic [7:0] mid, input logic [7:0] mx,
                          input bit fade, input bit perturb, input string tag);
    start_frame(cont, mid, mx, fade);
    wait_frame(1'b0, perturb, tag);
  endtask

  initial begin
    logic [31:0] rc;
    int r_exp;
    for (int k = 0; k < CH; k++) exp_cor[k] = '0;
    bus.enable   = 1'b1;
    bus.fade_en  = 1'b0;
    bus.contador = 32'h12345678;
    bus.mid_idx  = 8'd10;
    bus.max_idx  = 8'd20;

    // Reset held with enable high
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cor", bus.cor_led, 96'd0);
    chk("rst_busy", 96'(bus.busy), 96'd0);
    chk("rst_done", 96'(bus.frame_done), 96'd0);
    @(negedge clock);
    bus.enable = 1'b0;
    reset = 1'b1;

    // Directed gradient frames
    do_frame({8'd164, 8'd128, 8'd64, 8'd0}, 8'd128, 8'd200, 1'b0, 1'b0, "grad1");
    chk("grad1_const", bus.cor_led, {24'hFF8000, 24'hFFFF00, 24'h7FFF00, 24'h00FF00});
    chk("grad1_len_const", 96'(exp_len), 96'd73);
    do_frame({8'd0, 8'd129, 8'd250, 8'd200}, 8'd128, 8'd200, 1'b0, 1'b0, "grad2");
    chk("grad2_const", bus.cor_led, {24'h00FF00, 24'hFFFC00, 24'hFF0000, 24'hFF0000});

    // Divisor boundaries
    do_frame(32'h00000000, 8'd0, 8'd0, 1'b0, 1'b0, "den0");
    chk("den0_const", bus.cor_led[23:0], 96'h00FFFF00);
    do_frame({4{8'd150}}, 8'd100, 8'd50, 1'b0, 1'b0, "emax");
    chk("emax_const", bus.cor_led[23:0], 96'h00FF0000);
    do_frame({8'd101, 8'd100, 8'd99, 8'd100}, 8'd100, 8'd100, 1'b0, 1'b0, "midmax");
    chk("midmax_const", bus.cor_led[23:0], 96'h00FFFF00);

    // Snapshot: inputs scrambled while busy, enable already dropped
    do_frame({8'd164, 8'd128, 8'd64, 8'd0}, 8'd128, 8'd200, 1'b0, 1'b1, "snap");
    chk("snap_const", bus.cor_led, {24'hFF8000, 24'hFFFF00, 24'h7FFF00, 24'h00FF00});

    // Back-to-back frames with enable held: exactly one idle cycle between
    start_frame({8'd10, 8'd20, 8'd30, 8'd40}, 8'd50, 8'd90, 1'b0);
    wait_frame(1'b1, 1'b0, "b2b_a");
    model_frame({8'd10, 8'd20, 8'd30, 8'd40}, 50, 90, 1'b0);
    wait_frame(1'b0, 1'b0, "b2b_b");

    // Reset in the middle of a divide
    start_frame({8'd1, 8'd2, 8'd3, 8'd4}, 8'd200, 8'd250, 1'b0);
    repeat (6) @(negedge clock);
    bus.enable = 1'b0;
    chk("mid_busy", 96'(bus.busy), 96'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_cor", bus.cor_led, 96'd0);
    chk("midrst_busy", 96'(bus.busy), 96'd0);
    chk("midrst_done", 96'(bus.frame_done), 96'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < CH; k++) exp_cor[k] = '0;
    repeat (3) @(negedge clock);
    chk("midrst_stays_idle", 96'(bus.busy), 96'd0);

    // Fade from black toward red, then retarget to green
    for (int f = 1; f <= 17; f++) begin
      do_frame({4{8'd255}}, 8'd128, 8'd200, 1'b1, 1'b0, $sformatf("fade_r%0d", f));
      r_exp = (16 * f > 255) ? 255 : 16 * f;
      chk($sformatf("fade_r%0d_red", f), 96'(bus.cor_led[23:16]), 96'(r_exp));
    end
    for (int f = 1; f <= 4; f++) begin
      do_frame(32'h00000000, 8'd128, 8'd200, 1'b1, 1'b0, $sformatf("fade_g%0d", f));
      r_exp = 255 - 16 * f;
      chk($sformatf("fade_g%0d_ch2", f), 96'(bus.cor_led[71:48]),
          96'({r_exp[7:0], 8'(16 * f), 8'h00}));
    end

    // Randomized frames
    for (int i = 0; i < 25; i++) begin
      rc = $urandom;
      do_frame(rc, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
               $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
